nfca_tx_frame: RTL

Byte-level transmit framer for the ISO 14443-A reader path. It buffers outgoing frame bytes from the controller and serialises each frame as SOF, LSB-first data with per-byte odd parity, optional CRC_A and EOF. Bits are delivered to `nfca_tx_modulate` through its `tx_req`/`tx_en`/`tx_bit` bit-request handshake, so the framer decides frame boundaries and the modulator only encodes and times individual bits.

---
 rtl/nfca_pkg.sv | 31 +++
 rtl/nfca_tx_frame_if.sv | 23 ++
 rtl/nfca_tx_fifo.sv | 52 +++++
 rtl/nfca_tx_frame.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/nfca_pkg.sv
// Shared types for the NFC-A transmit framer: FSM states, CRC_A constants, buffer entry.
// Pure declarations; no timing or flow control of its own.
package nfca_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_PAR,
    ST_CRC,
    ST_EOF,
    ST_STOP
  } state_t;

  localparam logic [15:0] CRC_A_INIT = 16'h6363;
  localparam logic [15:0] CRC_A_POLY = 16'h8408;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] datab;
    logic       last;
    logic       crc;
  } buf_entry_t;

  // One LSB-first step of the reflected CRC_A register.
  function automatic logic [15:0] crc_a_bit(input logic [15:0] crc, input logic b);
    logic [15:0] sh;
    sh = crc >> 1;
    return (crc[0] ^ b) ? (sh ^ CRC_A_POLY) : sh;
  endfunction

endpackage

// File: rtl/nfca_tx_frame_if.sv
// Byte stream from the controller plus the bit-request handshake towards the modulator.
// master = controller/modulator side, slave = framer.
interface nfca_tx_frame_if;
  logic       tx_tvalid;
  logic       tx_tready;
  logic [7:0] tx_tdata;
  logic [2:0] tx_tdatab;
  logic       tx_tlast;
  logic       tx_tcrc;
  logic       tx_req;
  logic       tx_en;
  logic       tx_bit;

  modport master (
    output tx_tvalid, tx_tdata, tx_tdatab, tx_tlast, tx_tcrc, tx_req,
    input  tx_tready, tx_en, tx_bit
  );

  modport slave (
    input  tx_tvalid, tx_tdata, tx_tdatab, tx_tlast, tx_tcrc, tx_req,
    output tx_tready, tx_en, tx_bit
  );
endinterface

// File: rtl/nfca_tx_fifo.sv
// Show-ahead synchronous FIFO of buffer entries; dout is valid whenever not empty.
// Write visible one cycle later; push when full and pop when empty are ignored.
module nfca_tx_fifo
  import nfca_pkg::*;
#(
  parameter int BUF_DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push_i,
  input  buf_entry_t                 din_i,
  input  logic                       pop_i,
  output buf_entry_t                 dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(BUF_DEPTH):0] count_o
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam logic [AW:0] ONE = 1;

  buf_entry_t    mem_q [BUF_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          wr_en, rd_en;

  assign full_o  = (count_q == (AW+1)'(BUF_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign wr_en   = push_i & ~full_o;
  assign rd_en   = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + ONE;
        2'b01:   count_q <= count_q - ONE;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/nfca_tx_frame.sv
// ISO 14443-A transmit framer: SOF, LSB-first data + odd parity, optional CRC_A (NFCA_TX_CRC_EN), EOF.
// One bit per tx_req, outputs registered on the request edge; byte input stalls via tx_tready when full.
module nfca_tx_frame
  import nfca_pkg::*;
#(
  parameter int BUF_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  nfca_tx_frame_if.slave        bus,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  underrun
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;

  buf_entry_t    wr_entry, fifo_dout;
  logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CW-1:0] fifo_cnt;
  logic [CW-1:0] frames_ready_q;
  logic          rdy_q, drop_q;
  logic          start_ok, fsm_pop, wr_last, rd_last;
  logic [3:0]    entry_nbits;

  state_t        state_q;
  logic [7:0]    byte_q;
  logic [3:0]    nbits_q, bit_cnt_q;
  logic          last_q;
  logic          tx_en_q, tx_bit_q, busy_q, frame_done_q, underrun_q;
`ifdef NFCA_TX_CRC_EN
  logic [15:0]   crc_q;
  logic          crc_flag_q, crc_hi_q;
`else
  logic          crc_unused;
  assign crc_unused = fifo_dout.crc;
`endif

  assign wr_entry      = '{data: bus.tx_tdata, datab: bus.tx_tdatab, last: bus.tx_tlast, crc: bus.tx_tcrc};
  assign bus.tx_tready = rdy_q & ~fifo_full;
  assign fifo_push     = bus.tx_tvalid & bus.tx_tready;

  nfca_tx_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (fifo_push),
    .din_i   (wr_entry),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // A full buffer also starts a frame so frames longer than the buffer can stream.
  assign start_ok    = ~drop_q & ~fifo_empty &
                       ((frames_ready_q != '0) || (fifo_cnt == CW'(BUF_DEPTH)));
  assign entry_nbits = (fifo_dout.last && fifo_dout.datab != 3'd0) ? {1'b0, fifo_dout.datab} : 4'd8;

  always_comb begin
    fsm_pop = 1'b0;
    if (bus.tx_req) begin
      case (state_q)
        ST_IDLE: fsm_pop = start_ok;
        ST_PAR:  fsm_pop = ~last_q & ~fifo_empty;
        default: fsm_pop = 1'b0;
      endcase
    end
  end

  assign fifo_pop = fsm_pop | (drop_q & ~fifo_empty);
  assign wr_last  = fifo_push & bus.tx_tlast;
  assign rd_last  = fifo_pop & fifo_dout.last;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdy_q          <= 1'b0;
      frames_ready_q <= '0;
    end else begin
      rdy_q          <= 1'b1;
      frames_ready_q <= frames_ready_q + CW'(wr_last) - CW'(rd_last);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      byte_q       <= '0;
      nbits_q      <= 4'd8;
      bit_cnt_q    <= '0;
      last_q       <= 1'b0;
      drop_q       <= 1'b0;
      tx_en_q      <= 1'b0;
      tx_bit_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
`ifdef NFCA_TX_CRC_EN
      crc_q        <= CRC_A_INIT;
      crc_flag_q   <= 1'b0;
      crc_hi_q     <= 1'b0;
`endif
    end else begin
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
      if (drop_q && !fifo_empty && fifo_dout.last) drop_q <= 1'b0;
      if (bus.tx_req) begin
        case (state_q)
          ST_IDLE: begin
            if (start_ok) begin
              tx_en_q   <= 1'b1;
              tx_bit_q  <= 1'b0;
              busy_q    <= 1'b1;
              byte_q    <= fifo_dout.data;
              last_q    <= fifo_dout.last;
              nbits_q   <= entry_nbits;
              bit_cnt_q <= '0;
              state_q   <= ST_DATA;
`ifdef NFCA_TX_CRC_EN
              crc_q      <= CRC_A_INIT;
              crc_flag_q <= fifo_dout.crc;
`endif
            end else begin
              tx_en_q <= 1'b0;
            end
          end
          ST_DATA: begin
            tx_bit_q  <= byte_q[bit_cnt_q[2:0]];
            bit_cnt_q <= bit_cnt_q + 4'd1;
`ifdef NFCA_TX_CRC_EN
            crc_q     <= crc_a_bit(crc_q, byte_q[bit_cnt_q[2:0]]);
`endif
            // A short final byte carries no parity and ends the frame directly.
            if (bit_cnt_q == nbits_q - 4'd1)
              state_q <= (nbits_q == 4'd8) ? ST_PAR : ST_EOF;
          end
          ST_PAR: begin
            tx_bit_q <= ~^byte_q;
            if (last_q) begin
`ifdef NFCA_TX_CRC_EN
              if (crc_flag_q) begin
                byte_q    <= crc_q[7:0];
                bit_cnt_q <= '0;
                crc_hi_q  <= 1'b0;
                state_q   <= ST_CRC;
              end else begin
                state_q <= ST_EOF;
              end
`else
              state_q <= ST_EOF;
`endif
            end else if (!fifo_empty) begin
              byte_q    <= fifo_dout.data;
              last_q    <= fifo_dout.last;
              nbits_q   <= entry_nbits;
              bit_cnt_q <= '0;
              state_q   <= ST_DATA;
            end else begin
              underrun_q <= 1'b1;
              drop_q     <= 1'b1;
              state_q    <= ST_EOF;
            end
          end
`ifdef NFCA_TX_CRC_EN
          ST_CRC: begin
            // Count 0..7 are data bits, 8 is the parity slot of the current CRC byte.
            if (bit_cnt_q == 4'd8) begin
              tx_bit_q  <= ~^byte_q;
              bit_cnt_q <= '0;
              if (crc_hi_q) begin
                state_q <= ST_EOF;
              end else begin
                crc_hi_q <= 1'b1;
                byte_q   <= crc_q[15:8];
              end
            end else begin
              tx_bit_q  <= byte_q[bit_cnt_q[2:0]];
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
`endif
          ST_EOF: begin
            tx_bit_q <= 1'b0;
            state_q  <= ST_STOP;
          end
          ST_STOP: begin
            tx_en_q      <= 1'b0;
            frame_done_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.tx_en  = tx_en_q;
  assign bus.tx_bit = tx_bit_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;
endmodule
